// File: rtl/cpack_line_packer.sv
`default_nettype none
// ============================================================================
//  Module   : cpack_line_packer
//  Purpose  : Packs variable-length compressed fragments into fixed-width
//             cache lines. Supports an optional split mode, in which a
//             fragment that overflows the line continues in the next line,
//             and an explicit end-of-line flush.
//  Revision : 1.0  initial parameterised release
// ============================================================================
module cpack_line_packer #(
   parameter int LINE_W = 128,
   parameter int FRAG_W = 68,
   parameter int LEN_W  = 8,
   parameter int SPLIT  = 0,
   parameter int CNT_W  = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [FRAG_W-1:0] i_frag,
   input  logic [LEN_W-1:0]  i_len,
   input  logic              i_last,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [LINE_W-1:0] o_line,
   output logic [LEN_W-1:0]  o_fill,
   output logic              o_split,
   output logic [CNT_W-1:0]  o_line_cnt,
   output logic              o_err
);

   // The accumulator must hold a nearly full line plus one whole fragment.
   localparam int c_acc_w = LINE_W + FRAG_W;

   // Line width at the widths used for the sum and the fill fields.
   localparam logic [LEN_W:0]   c_line_s = (LEN_W+1)'(LINE_W);
   localparam logic [LEN_W-1:0] c_line_l = LEN_W'(LINE_W);
   localparam logic [LEN_W-1:0] c_frag_l = LEN_W'(FRAG_W);

   localparam bit c_split = (SPLIT != 0);

   // FSM encoding
   localparam logic [0:0] c_st_acc   = 1'b0;
   localparam logic [0:0] c_st_flush = 1'b1;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [0:0]         r_state;
   logic [c_acc_w-1:0] r_acc;
   logic [LEN_W-1:0]   r_fill;
   logic               r_valid;
   logic [LINE_W-1:0]  r_line;
   logic [LEN_W-1:0]   r_fill_out;
   logic               r_split;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_err;

   // ------------------------------------------------------------------------
   // Combinational datapath
   // ------------------------------------------------------------------------
   logic [FRAG_W-1:0]  w_mask;
   logic [FRAG_W-1:0]  w_frag_m;
   logic [c_acc_w-1:0] w_frag_ext;
   logic [c_acc_w-1:0] w_merged;
   logic [LEN_W:0]     w_sum;
   logic [LEN_W-1:0]   w_over;
   logic               w_len_bad;
   logic               w_out_free;
   logic               w_accept;

   // Next-state values produced by the packing decision
   logic               w_ld_out;
   logic [LINE_W-1:0]  w_ld_line;
   logic [LEN_W-1:0]   w_ld_fill;
   logic               w_ld_split;
   logic [c_acc_w-1:0] w_acc_nxt;
   logic [LEN_W-1:0]   w_fill_nxt;
   logic [0:0]         w_state_nxt;
   logic               w_err_set;

   // The output slot can take a new line when empty or being drained now.
   assign w_out_free = !r_valid || i_ready;

   // Beats are only taken in ACC and never while reset is asserted.
   assign o_ready  = i_reset && (r_state == c_st_acc) && w_out_free;
   assign w_accept = i_valid && o_ready;

   assign w_len_bad = (i_len > c_frag_l);

   // Keep only the low i_len bits of the incoming fragment.
   always_comb begin
      w_mask = '0;
      for (int k = 0; k < FRAG_W; k++) begin
         w_mask[k] = (k < int'(i_len));
      end
   end

   assign w_frag_m   = i_frag & w_mask;
   assign w_frag_ext = {{LINE_W{1'b0}}, w_frag_m};

   // The accumulator only ever holds masked bits, so OR-ing in place is safe.
   assign w_merged = r_acc | (w_frag_ext << r_fill);

   // One extra bit on the sum so fill + len can never wrap.
   assign w_sum  = {1'b0, r_fill} + {1'b0, i_len};
   // Overflow amount; the true result is below LINE_W so the low bits suffice.
   assign w_over = w_sum[LEN_W-1:0] - c_line_l;

   // Decide what the accepted beat (or a pending flush) does to the state.
   always_comb begin
      w_ld_out    = 1'b0;
      w_ld_line   = '0;
      w_ld_fill   = '0;
      w_ld_split  = 1'b0;
      w_acc_nxt   = r_acc;
      w_fill_nxt  = r_fill;
      w_state_nxt = r_state;
      w_err_set   = 1'b0;

      if (r_state == c_st_flush) begin
         // Drain the leftover partial line once the output slot is free.
         if (w_out_free) begin
            w_ld_out    = 1'b1;
            w_ld_line   = r_acc[LINE_W-1:0];
            w_ld_fill   = r_fill;
            w_acc_nxt   = '0;
            w_fill_nxt  = '0;
            w_state_nxt = c_st_acc;
         end
      end else if (w_accept) begin
         if (w_len_bad) begin
            // Malformed beat: swallow it and only raise the error flag.
            w_err_set = 1'b1;
         end else if (w_sum < c_line_s) begin
            if (i_last && (w_sum != '0)) begin
               w_ld_out   = 1'b1;
               w_ld_line  = w_merged[LINE_W-1:0];
               w_ld_fill  = w_sum[LEN_W-1:0];
               w_acc_nxt  = '0;
               w_fill_nxt = '0;
            end else begin
               w_acc_nxt  = w_merged;
               w_fill_nxt = w_sum[LEN_W-1:0];
            end
         end else if (w_sum == c_line_s) begin
            // Exact fit closes the line in both modes.
            w_ld_out   = 1'b1;
            w_ld_line  = w_merged[LINE_W-1:0];
            w_ld_fill  = c_line_l;
            w_acc_nxt  = '0;
            w_fill_nxt = '0;
         end else if (c_split) begin
            // Fill the line to the brim and carry the overflow to bit 0.
            w_ld_out   = 1'b1;
            w_ld_line  = w_merged[LINE_W-1:0];
            w_ld_fill  = c_line_l;
            w_ld_split = 1'b1;
            w_acc_nxt  = w_merged >> LINE_W;
            w_fill_nxt = w_over;
            if (i_last) begin
               w_state_nxt = c_st_flush;
            end
         end else begin
            // Close the current line short; the fragment starts a new one.
            w_ld_out   = 1'b1;
            w_ld_line  = r_acc[LINE_W-1:0];
            w_ld_fill  = r_fill;
            w_acc_nxt  = w_frag_ext;
            w_fill_nxt = i_len;
            if (i_last) begin
               w_state_nxt = c_st_flush;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Sequential logic
   // ------------------------------------------------------------------------

   // Accumulator, fill level and FSM state.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= c_st_acc;
         r_acc   <= '0;
         r_fill  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_fill  <= w_fill_nxt;
      end
   end

   // Output register: load a finished line or drop it once consumed.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_valid    <= 1'b0;
         r_line     <= '0;
         r_fill_out <= '0;
         r_split    <= 1'b0;
      end else if (w_ld_out) begin
         r_valid    <= 1'b1;
         r_line     <= w_ld_line;
         r_fill_out <= w_ld_fill;
         r_split    <= w_ld_split;
      end else if (i_ready) begin
         r_valid    <= 1'b0;
      end
   end

   // Emitted-line counter and sticky length error.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_ld_out) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_err_set) begin
            r_err <= 1'b1;
         end
      end
   end

   assign o_valid    = r_valid;
   assign o_line     = r_line;
   assign o_fill     = r_fill_out;
   assign o_split    = r_split;
   assign o_line_cnt = r_cnt;
   assign o_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cpack_line_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpack_line_packer
//  Purpose  : Self-checking bench for cpack_line_packer, one instance per
//             overflow mode, against a bit-stream reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpack_line_packer;

   localparam int LINE_W = 128;
   localparam int FRAG_W = 68;
   localparam int LEN_W  = 8;
   localparam int CNT_W  = 16;

   logic i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   logic              rst_n     = 1'b0;
   logic              drv_valid = 1'b0;
   int                sel       = 0;
   logic [FRAG_W-1:0] frag      = '0;
   logic [LEN_W-1:0]  len       = '0;
   logic              last      = 1'b0;
   logic              rdy_in    = 1'b1;

   logic v0_in, v1_in;
   assign v0_in = drv_valid && (sel == 0);
   assign v1_in = drv_valid && (sel == 1);

   logic              rdy0, ov0, split0, err0;
   logic [LINE_W-1:0] line0;
   logic [LEN_W-1:0]  fill0;
   logic [CNT_W-1:0]  cnt0;
   logic              rdy1, ov1, split1, err1;
   logic [LINE_W-1:0] line1;
   logic [LEN_W-1:0]  fill1;
   logic [CNT_W-1:0]  cnt1;

   cpack_line_packer #(.LINE_W(LINE_W), .FRAG_W(FRAG_W), .LEN_W(LEN_W), .SPLIT(0), .CNT_W(CNT_W)) u_dut0 (
      .i_clk(i_clk), .i_reset(rst_n), .i_valid(v0_in), .o_ready(rdy0),
      .i_frag(frag), .i_len(len), .i_last(last), .o_valid(ov0), .i_ready(rdy_in),
      .o_line(line0), .o_fill(fill0), .o_split(split0), .o_line_cnt(cnt0), .o_err(err0));

   cpack_line_packer #(.LINE_W(LINE_W), .FRAG_W(FRAG_W), .LEN_W(LEN_W), .SPLIT(1), .CNT_W(CNT_W)) u_dut1 (
      .i_clk(i_clk), .i_reset(rst_n), .i_valid(v1_in), .o_ready(rdy1),
      .i_frag(frag), .i_len(len), .i_last(last), .o_valid(ov1), .i_ready(rdy_in),
      .o_line(line1), .o_fill(fill1), .o_split(split1), .o_line_cnt(cnt1), .o_err(err1));

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(string n, logic [255:0] a, logic [255:0] x);
      n_checks++;
      if (a !== x) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, x);
      end
   endtask

   // ---------------- reference model: a plain bit stream ----------------
   typedef struct {
      logic [LINE_W-1:0] line;
      int                fill;
      bit                split;
   } line_t;

   line_t        q0[$];
   line_t        q1[$];
   logic [255:0] m_acc[2];
   int           m_fill[2];
   bit           m_err[2];
   int           popped[2];
   bit           held[2];
   line_t        held_v[2];

   task automatic push(int d, logic [255:0] a, int f, bit s);
      line_t e;
      e.line  = a[LINE_W-1:0];
      e.fill  = f;
      e.split = s;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic model_clear();
      q0.delete();
      q1.delete();
      for (int d = 0; d < 2; d++) begin
         m_acc[d] = '0; m_fill[d] = 0; m_err[d] = 0; popped[d] = 0; held[d] = 0;
      end
   endtask

   task automatic model_beat(int d, logic [FRAG_W-1:0] fr, int ln, bit ls);
      logic [255:0] m;
      m = '0;
      if (ln > FRAG_W) begin
         m_err[d] = 1'b1;
         return;
      end
      for (int k = 0; k < ln; k++) m[k] = fr[k];
      if (d == 0) begin
         // no splitting: a fragment that does not fit opens a new line
         if (m_fill[d] + ln > LINE_W) begin
            push(d, m_acc[d], m_fill[d], 1'b0);
            m_acc[d]  = m;
            m_fill[d] = ln;
         end else begin
            m_acc[d]  = m_acc[d] | (m << m_fill[d]);
            m_fill[d] = m_fill[d] + ln;
         end
         if (m_fill[d] == LINE_W || (ls && m_fill[d] > 0)) begin
            push(d, m_acc[d], m_fill[d], 1'b0);
            m_acc[d] = '0; m_fill[d] = 0;
         end
      end else begin
         // continuous bit stream cut into LINE_W chunks
         m_acc[d]  = m_acc[d] | (m << m_fill[d]);
         m_fill[d] = m_fill[d] + ln;
         if (m_fill[d] >= LINE_W) begin
            push(d, m_acc[d], LINE_W, m_fill[d] > LINE_W);
            m_acc[d]  = m_acc[d] >> LINE_W;
            m_fill[d] = m_fill[d] - LINE_W;
         end
         if (ls && m_fill[d] > 0) begin
            push(d, m_acc[d], m_fill[d], 1'b0);
            m_acc[d] = '0; m_fill[d] = 0;
         end
      end
   endtask

   // ---------------- per-cycle compare ----------------
   task automatic cmp_dut(int d, logic v, logic [LINE_W-1:0] l, logic [LEN_W-1:0] f,
                          logic s, logic [CNT_W-1:0] c, logic e);
      line_t x;
      chk($sformatf("err%0d", d), e, m_err[d]);
      if (held[d]) begin
         chk($sformatf("hold_valid%0d", d), v, 1'b1);
         chk($sformatf("hold_line%0d", d), l, held_v[d].line);
         chk($sformatf("hold_fill%0d", d), f, held_v[d].fill);
         chk($sformatf("hold_split%0d", d), s, held_v[d].split);
      end
      held[d] = 1'b0;
      if (v) begin
         chk($sformatf("cnt%0d", d), c, CNT_W'(popped[d] + 1));
         if (rdy_in) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_line%0d: got fill %0d expected no line", d, f);
            end else begin
               x = (d == 0) ? q0.pop_front() : q1.pop_front();
               chk($sformatf("line%0d", d), l, x.line);
               chk($sformatf("fill%0d", d), f, x.fill);
               chk($sformatf("split%0d", d), s, x.split);
               popped[d]++;
            end
         end else begin
            held[d]        = 1'b1;
            held_v[d].line = l;
            held_v[d].fill = int'(f);
            held_v[d].split = s;
         end
      end else begin
         chk($sformatf("cnt_idle%0d", d), c, CNT_W'(popped[d]));
      end
   endtask

   always @(negedge i_clk) begin
      if (rst_n) begin
         cmp_dut(0, ov0, line0, fill0, split0, cnt0, err0);
         cmp_dut(1, ov1, line1, fill1, split1, cnt1, err1);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   function automatic logic [FRAG_W-1:0] rnd68();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[FRAG_W-1:0];
   endfunction

   task automatic send(logic [FRAG_W-1:0] fr, int ln, bit ls, output int stalls);
      bit done;
      done   = 1'b0;
      stalls = 0;
      frag = fr; len = LEN_W'(ln); last = ls; drv_valid = 1'b1;
      for (int t = 0; t < 50; t++) begin
         @(negedge i_clk);
         if ((sel == 0) ? rdy0 : rdy1) begin
            @(posedge i_clk);
            model_beat(sel, fr, ln, ls);
            done = 1'b1;
            break;
         end
         stalls++;
      end
      if (!done) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: got no o_ready expected acceptance within 50 cycles");
         @(posedge i_clk);
      end
      #1;
      drv_valid = 1'b0;
   endtask

   task automatic beat(logic [FRAG_W-1:0] fr, int ln, bit ls);
      int st;
      send(fr, ln, ls, st);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge i_clk);
      chk("rst_ready0", rdy0, 1'b0);
      chk("rst_ready1", rdy1, 1'b0);
      @(posedge i_clk);
      model_clear();
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int st;
      int t1_len[6] = '{40, 12, 12, 24, 32, 8};
      logic [31:0] w[4] = '{32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C, 32'h4B5A6978};

      model_clear();
      do_reset();
      @(negedge i_clk);
      chk("reset_valid0", ov0, 1'b0);
      chk("reset_valid1", ov1, 1'b0);
      chk("reset_cnt0", cnt0, '0);
      chk("reset_err0", err0, 1'b0);
      chk("reset_ready0", rdy0, 1'b1);
      tick();

      // T1: six beats totalling exactly one line, no stalls
      sel = 0;
      for (int i = 0; i < 6; i++) begin
         send('1, t1_len[i], 1'b0, st);
         chk("t1_stall", st, 0);
      end
      @(negedge i_clk);
      chk("t1_valid", ov0, 1'b1);
      chk("t1_fill", fill0, 128);
      chk("t1_line", line0, {LINE_W{1'b1}});
      chk("t1_cnt", cnt0, 1);
      chk("t1_ready", rdy0, 1'b1);
      tick();
      @(negedge i_clk);
      chk("t1_valid_drop", ov0, 1'b0);
      tick();

      // T2: overflow opens a new line, then a zero-length flush
      beat(rnd68(), 48, 1'b0);
      beat(rnd68(), 8, 1'b0);
      beat(rnd68(), 68, 1'b0);
      beat(rnd68(), 8, 1'b0);
      @(negedge i_clk);
      chk("t2_fill124", fill0, 124);
      chk("t2_split", split0, 1'b0);
      tick();
      beat(rnd68(), 0, 1'b1);
      @(negedge i_clk);
      chk("t2_fill8", fill0, 8);
      chk("t2_cnt", cnt0, 3);
      tick();
      beat(rnd68(), 0, 1'b1);   // empty flush emits nothing
      tick();

      // T3: split mode carries overflow bits into the next line
      sel = 1;
      beat(rnd68(), 68, 1'b0);
      beat(rnd68(), 56, 1'b0);
      beat(68'hAB, 8, 1'b0);
      @(negedge i_clk);
      chk("t3_fill", fill1, 128);
      chk("t3_split", split1, 1'b1);
      chk("t3_top", line1[127:124], 4'hB);
      tick();
      beat(68'h0, 0, 1'b1);
      @(negedge i_clk);
      chk("t3_rest_fill", fill1, 4);
      chk("t3_rest_bits", line1[3:0], 4'hA);
      chk("t3_rest_split", split1, 1'b0);
      tick();
      beat(rnd68(), 68, 1'b0);
      beat(rnd68(), 56, 1'b0);
      beat(68'hCD, 8, 1'b1);
      @(negedge i_clk);
      chk("t3b_fill", fill1, 128);
      chk("t3b_ready", rdy1, 1'b0);
      tick();
      @(negedge i_clk);
      chk("t3b_rest_fill", fill1, 4);
      chk("t3b_rest_bits", line1[3:0], 4'hC);
      tick();

      // T4: overflow with last enters FLUSH
      sel = 0;
      beat(rnd68(), 68, 1'b0);
      beat(rnd68(), 32, 1'b0);
      beat(rnd68(), 40, 1'b1);
      @(negedge i_clk);
      chk("t4_fill100", fill0, 100);
      chk("t4_flush_ready", rdy0, 1'b0);
      tick();
      @(negedge i_clk);
      chk("t4_fill40", fill0, 40);
      chk("t4_ready_back", rdy0, 1'b1);
      tick();
      // same with a stalled consumer
      rdy_in = 1'b0;
      beat(rnd68(), 68, 1'b0);
      beat(rnd68(), 32, 1'b0);
      beat(rnd68(), 40, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         chk("t4_hold_fill", fill0, 100);
         chk("t4_hold_ready", rdy0, 1'b0);
         tick();
      end
      rdy_in = 1'b1;
      @(negedge i_clk);
      tick();
      @(negedge i_clk);
      chk("t4_after_fill", fill0, 40);
      chk("t4_after_valid", ov0, 1'b1);
      tick();

      // T5: oversize length, then reset mid-line
      beat(rnd68(), 30, 1'b0);
      beat(rnd68(), 70, 1'b0);
      @(negedge i_clk);
      chk("t5_err", err0, 1'b1);
      tick();
      beat(rnd68(), 68, 1'b0);
      beat(rnd68(), 30, 1'b0);
      @(negedge i_clk);
      chk("t5_fill_kept", fill0, 128);
      tick();
      beat(rnd68(), 40, 1'b0);
      do_reset();
      @(negedge i_clk);
      chk("t5_rst_err", err0, 1'b0);
      chk("t5_rst_valid", ov0, 1'b0);
      chk("t5_rst_cnt", cnt0, '0);
      tick();
      for (int i = 0; i < 4; i++) beat({36'hFFFFFFFFF, w[i]}, 32, 1'b0);
      @(negedge i_clk);
      chk("t5_line", line0, {w[3], w[2], w[1], w[0]});
      chk("t5_fill", fill0, 128);
      tick();

      repeat (4) tick();
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpack_line_packer.md
# cpack_line_packer

Parametrised packer for variable-length compressed codewords. It sits behind the pair-compressor stage and turns (fragment, length) beats into fixed-width compressed cache lines over a valid/ready output. It succeeds the fixed 128-bit stop/finish packing with three additions: configurable line and fragment widths, an optional split mode that carries overflow bits into the next line, and an explicit end-of-line flush.

## Interface
- LINE_W, 128, output cache-line width in bits
- FRAG_W, 68, maximum fragment width (two 34-bit codewords)
- LEN_W, 8, width of the length fields; must hold the value LINE_W
- SPLIT, 0, overflow mode: 0 = a fragment that does not fit starts a new line; 1 = it is split across lines
- CNT_W, 16, width of the emitted-line counter
- i_clk  in  1  the single clock; all logic is on the rising edge
- i_reset  in  1  synchronous reset, active-low
- i_valid  in  1  fragment beat valid
- o_ready  out  1  the packer accepts a beat this cycle
- i_frag  in  FRAG_W  codeword bits, LSB-aligned; bits at or above i_len are ignored (masked)
- i_len  in  LEN_W  fragment length, 0..FRAG_W
- i_last  in  1  flush the partial line after this fragment
- o_valid  out  1  o_line holds a line
- i_ready  in  1  the downstream side takes the line
- o_line  out  LINE_W  packed line; first fragment starts at bit 0; bits at or above o_fill are 0
- o_fill  out  LEN_W  number of valid bits in o_line
- o_split  out  1  the last fragment of this line continues in the next line (SPLIT=1 only)
- o_line_cnt  out  CNT_W  count of emitted lines, wraps
- o_err  out  1  sticky flag: a beat arrived with i_len > FRAG_W

## Operation
- State: accumulator acc_r (LINE_W+FRAG_W bits), fill_r, output register (o_line/o_fill/o_split/o_valid), and an FSM with states ACC and FLUSH.
- Handshake:
  - In ACC, o_ready = !o_valid || i_ready. This is a combinational path from i_ready.
  - In FLUSH, o_ready = 0.
  - While i_reset = 0, o_ready = 0.
- A beat is accepted when i_valid && o_ready. The fragment is masked to i_len bits and placed at bit offset fill_r. Let S = fill_r + i_len.
- S < LINE_W: the fragment is appended and fill_r = S. If i_last and S > 0, the line is emitted with o_fill = S and fill_r returns to 0.
- S == LINE_W: the line is emitted with o_fill = LINE_W and fill_r = 0, in either mode.
- S > LINE_W, SPLIT=0:
  - The current accumulator is emitted with o_fill = fill_r and o_split = 0.
  - The accumulator is loaded with the fragment and fill_r = i_len.
  - If i_last is also set, the FSM goes to FLUSH.
- S > LINE_W, SPLIT=1:
  - The line is emitted with o_fill = LINE_W and o_split = 1. It holds the low (LINE_W − fill_r) fragment bits.
  - The remaining S − LINE_W bits move to accumulator bit 0 and fill_r = S − LINE_W.
  - If i_last is also set, the FSM goes to FLUSH.
- FLUSH: when !o_valid || i_ready, the accumulator is moved to the output register (o_fill = fill_r, o_split = 0), fill_r = 0, and the FSM returns to ACC.
- i_len = 0 with i_last: this is a flush only. If fill_r = 0, no line is emitted.
- i_len > FRAG_W: the beat is accepted and dropped, o_err is set, and no other state changes.
- o_line_cnt increments on every line load into the output register.
- Arithmetic: S is computed at LEN_W+1 bits, so no wrap is possible.

## Timing
- Reset (i_reset low at a clock edge) clears all of the following: o_valid, o_line, o_fill, o_split, o_line_cnt, o_err, fill_r, and the FSM (to ACC).
- A reset taken mid-line discards the partial line and any pending output.
- Latency: a line is in o_line with o_valid = 1 in the cycle after the accepting edge. From FLUSH, the second line appears one cycle after the first is taken.
- o_valid, o_line, o_fill and o_split hold stable while i_ready = 0. Consuming the held line and accepting a new beat can happen in the same edge.
- Full throughput: one beat per cycle while i_ready = 1. The only bubble is the single FLUSH cycle.
- o_err clears only on reset.

## Test plan
- SPLIT=0, i_ready=1, lengths 40, 12, 12, 24, 32, 8 -> one line, o_fill=128, o_valid for 1 cycle after the 6th beat; o_ready stays 1; o_line_cnt=1.
- SPLIT=0, lengths 48, 8, 68, then 8 -> the 4th beat emits a line with o_fill=124; then 0 len with i_last -> a line with o_fill=8; o_line_cnt +2.
- SPLIT=1, fill 124, fragment 0xAB (len 8) -> line with o_fill=128, o_line[127:124]=0xB, o_split=1; a following i_last flush -> line o_fill=4, o_line[3:0]=0xA.
- SPLIT=0, fill 100, len 40 with i_last -> line fill 100, then o_ready=0 for one cycle, then line fill 40; with i_ready=0 the lines are held stable and in order.
- i_len=70 -> o_err=1, fill_r unchanged; then i_reset=0 for one cycle mid-line -> o_err=0, o_valid=0, fill 0, and a new 128-bit sequence packs from bit 0.
